// File: rtl/axi_pattern_test_master.sv
// ---------------------------------------------------------------------------
// axi_pattern_test_master
//
// Start-triggered AXI4 master for DDR-controller self-test. On an accepted
// start it writes a 2^A_WIDTH_TEST-byte region from address 0. It uses one of
// three data patterns: incrementing address, inverted address, or a 32-bit
// Galois LFSR. It then reads the region back and checks every beat for data,
// rlast and rresp. The write/read pair repeats NUM_PASSES times, then done
// is raised. Errors are counted and pulsed but never stop the test.
//
// Ports
//   aclk, aresetn       clock, asynchronous active-low reset
//   start, mode[1:0]    1-cycle start request (IDLE/DONE only), pattern select
//   busy, done          run in progress / run finished
//   pass_cnt[7:0]       completed write+read passes
//   aw*, w*, b*         AXI4 write address / data / response (bready tied 1)
//   ar*, r*             AXI4 read address / data (rready tied 1)
//   error, error_cnt    1-cycle pulse per faulty beat, saturating fault count
//
// Optional feature (macro AXI_TEST_ERR_CAPTURE_EN)
//   Adds first_err_addr, first_err_data and first_err_valid. They hold the
//   beat address and rdata of the first faulty read beat since the last start.
// ---------------------------------------------------------------------------
module axi_pattern_test_master #(
    parameter int          A_WIDTH_TEST = 26,
    parameter int          A_WIDTH      = 26,
    parameter int          D_WIDTH      = 16,
    parameter int          D_LEVEL      = 1,
    parameter logic [7:0]  WBURST_LEN   = 8'd7,
    parameter logic [7:0]  RBURST_LEN   = 8'd7,
    parameter int          NUM_PASSES   = 1,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1ACE1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           pass_cnt,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [A_WIDTH-1:0]   awaddr,
    output logic [7:0]           awlen,
    output logic                 wvalid,
    input  logic                 wready,
    output logic                 wlast,
    output logic [D_WIDTH-1:0]   wdata,
    output logic [D_WIDTH/8-1:0] wstrb,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic [1:0]           bresp,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [A_WIDTH-1:0]   araddr,
    output logic [7:0]           arlen,
    input  logic                 rvalid,
    output logic                 rready,
    input  logic                 rlast,
    input  logic [1:0]           rresp,
    input  logic [D_WIDTH-1:0]   rdata,
`ifdef AXI_TEST_ERR_CAPTURE_EN
    output logic [A_WIDTH-1:0]   first_err_addr,
    output logic [D_WIDTH-1:0]   first_err_data,
    output logic                 first_err_valid,
`endif
    output logic                 error,
    output logic [15:0]          error_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    localparam logic [31:0]      LFSR_TAPS   = 32'h80200003;
    localparam logic [A_WIDTH:0] ADDR_STEP   = {{A_WIDTH{1'b0}}, 1'b1} << D_LEVEL;
    localparam logic [7:0]       PASSES_LAST = 8'(NUM_PASSES - 1);

    // Galois LFSR, shifting right; taps folded in when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Data for one beat. Mode 3 falls through to the incrementing pattern.
    function automatic logic [D_WIDTH-1:0] beat_pattern(input logic [1:0]         m,
                                                        input logic [A_WIDTH-1:0] a,
                                                        input logic [31:0]        l);
        logic [D_WIDTH-1:0] incr;
        logic [D_WIDTH-1:0] rep;
        incr = D_WIDTH'(a);
        for (int i = 0; i < D_WIDTH; i++) begin
            rep[i] = l[i % 32];
        end
        case (m)
            2'd1:    return ~incr;
            2'd2:    return rep;
            default: return incr;
        endcase
    endfunction

    state_t             state;
    logic [1:0]         mode_q;
    logic [A_WIDTH-1:0] w_addr;         // address of the current write beat
    logic [A_WIDTH-1:0] r_addr;         // address of the current read beat
    logic [A_WIDTH-1:0] awaddr_q;
    logic [A_WIDTH-1:0] araddr_q;
    logic [7:0]         w_beat;
    logic [7:0]         r_beat;
    logic               w_wrap;         // last write burst reached region end
    logic [31:0]        w_lfsr;
    logic [31:0]        r_lfsr;
    logic [7:0]         pass_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [15:0]        error_cnt_q;
`ifdef AXI_TEST_ERR_CAPTURE_EN
    logic [A_WIDTH-1:0] first_err_addr_q;
    logic [D_WIDTH-1:0] first_err_data_q;
    logic               first_err_valid_q;
`endif

    // Next beat address carries one extra bit so that reaching the end of the
    // region is visible even when the region spans the whole address space.
    logic [A_WIDTH:0]   w_addr_nxt;
    logic [A_WIDTH:0]   r_addr_nxt;
    logic               w_end;
    logic               r_end;
    logic [D_WIDTH-1:0] r_expected;
    logic               r_last_exp;
    logic               rd_fault;
    logic               b_fault;

    assign w_addr_nxt = {1'b0, w_addr} + ADDR_STEP;
    assign r_addr_nxt = {1'b0, r_addr} + ADDR_STEP;
    assign w_end      = w_addr_nxt[A_WIDTH_TEST];
    assign r_end      = r_addr_nxt[A_WIDTH_TEST];
    assign r_expected = beat_pattern(mode_q, r_addr, r_lfsr);
    assign r_last_exp = (r_beat == RBURST_LEN);
    assign rd_fault   = (state == S_R) && rvalid &&
                        ((rdata != r_expected) || (rresp != 2'b00) || (rlast != r_last_exp));
    assign b_fault    = (state == S_B) && bvalid && (bresp != 2'b00);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            mode_q      <= 2'd0;
            w_addr      <= '0;
            r_addr      <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            w_beat      <= 8'd0;
            r_beat      <= 8'd0;
            w_wrap      <= 1'b0;
            w_lfsr      <= LFSR_SEED;
            r_lfsr      <= LFSR_SEED;
            pass_cnt_q  <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            error_cnt_q <= 16'd0;
`ifdef AXI_TEST_ERR_CAPTURE_EN
            first_err_addr_q  <= '0;
            first_err_data_q  <= '0;
            first_err_valid_q <= 1'b0;
`endif
        end else begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values; a blocking write would leak into later reads.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_AW;
                        mode_q      <= mode;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_cnt_q  <= 8'd0;
                        error_cnt_q <= 16'd0;
                        w_addr      <= '0;
                        r_addr      <= '0;
                        awaddr_q    <= '0;
                        araddr_q    <= '0;
                        w_beat      <= 8'd0;
                        r_beat      <= 8'd0;
                        w_lfsr      <= LFSR_SEED;
                        r_lfsr      <= LFSR_SEED;
`ifdef AXI_TEST_ERR_CAPTURE_EN
                        first_err_valid_q <= 1'b0;
                        first_err_addr_q  <= '0;
                        first_err_data_q  <= '0;
`endif
                    end
                end
                S_AW: begin
                    if (awready) state <= S_W;
                end
                S_W: begin
                    if (wready) begin
                        w_addr <= w_addr_nxt[A_WIDTH-1:0];
                        w_lfsr <= lfsr_step(w_lfsr);
                        if (w_beat == WBURST_LEN) begin
                            w_beat   <= 8'd0;
                            w_wrap   <= w_end;
                            awaddr_q <= w_addr_nxt[A_WIDTH-1:0];
                            state    <= S_B;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) state <= w_wrap ? S_AR : S_AW;
                end
                S_AR: begin
                    if (arready) state <= S_R;
                end
                S_R: begin
                    if (rvalid) begin
                        r_addr <= r_addr_nxt[A_WIDTH-1:0];
                        r_lfsr <= lfsr_step(r_lfsr);
                        if (r_last_exp) begin
                            r_beat   <= 8'd0;
                            araddr_q <= r_addr_nxt[A_WIDTH-1:0];
                            if (!r_end) begin
                                state <= S_AR;
                            end else begin
                                pass_cnt_q <= pass_cnt_q + 8'd1;
                                if (pass_cnt_q == PASSES_LAST) begin
                                    state  <= S_DONE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    // Next pass: same region, same pattern sequence.
                                    state    <= S_AW;
                                    w_addr   <= '0;
                                    r_addr   <= '0;
                                    awaddr_q <= '0;
                                    araddr_q <= '0;
                                    w_lfsr   <= LFSR_SEED;
                                    r_lfsr   <= LFSR_SEED;
                                end
                            end
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Faults only occur in B or R, so they never collide with the
            // counter clear on start.
            error_q <= rd_fault || b_fault;
            if ((rd_fault || b_fault) && (error_cnt_q != 16'hFFFF)) begin
                error_cnt_q <= error_cnt_q + 16'd1;
            end
`ifdef AXI_TEST_ERR_CAPTURE_EN
            if (rd_fault && !first_err_valid_q) begin
                first_err_valid_q <= 1'b1;
                first_err_addr_q  <= r_addr;
                first_err_data_q  <= rdata;
            end
`endif
        end
    end

    // Valids decode straight from the state register. Address and data come
    // from registers that only move on a handshake, so they hold while stalled.
    assign awvalid   = (state == S_AW);
    assign wvalid    = (state == S_W);
    assign arvalid   = (state == S_AR);
    assign wlast     = (state == S_W) && (w_beat == WBURST_LEN);
    assign wdata     = beat_pattern(mode_q, w_addr, w_lfsr);
    assign wstrb     = '1;
    assign awaddr    = awaddr_q;
    assign araddr    = araddr_q;
    assign awlen     = WBURST_LEN;
    assign arlen     = RBURST_LEN;
    assign bready    = 1'b1;
    assign rready    = 1'b1;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_cnt  = pass_cnt_q;
    assign error     = error_q;
    assign error_cnt = error_cnt_q;
`ifdef AXI_TEST_ERR_CAPTURE_EN
    assign first_err_addr  = first_err_addr_q;
    assign first_err_data  = first_err_data_q;
    assign first_err_valid = first_err_valid_q;
`endif

endmodule

// File: tb/tb_axi_pattern_test_master.sv
// ---------------------------------------------------------------------------
// tb_axi_pattern_test_master
//
// Drives axi_pattern_test_master against a small AXI4 memory model covering a
// 64-byte region (16-bit beats, 4-beat bursts, two passes per start). The
// expected AW/AR addresses and W beats are pushed to queues before each start.
// They are popped as the memory model records each handshake. Fault knobs make
// the model corrupt data, drop rlast, or return error responses. Optional
// random stalls hold the ready signals low for 5 cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_pattern_test_master;

    localparam int          AWT    = 6;
    localparam int          AW     = 26;
    localparam int          DW     = 16;
    localparam int          PASSES = 2;
    localparam logic [7:0]  BLEN   = 8'd3;
    localparam logic [31:0] SEED   = 32'hACE1ACE1;
    localparam int          BURSTS = (1 << AWT) / 8;
    localparam int          BEATS  = BURSTS * 4;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic [1:0]    mode;
    logic          busy, done, error;
    logic [7:0]    pass_cnt;
    logic [15:0]   error_cnt;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    wstrb;
    logic [1:0]    bresp, rresp;
`ifdef AXI_TEST_ERR_CAPTURE_EN
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
    logic          first_err_valid;
`endif

    axi_pattern_test_master #(
        .A_WIDTH_TEST(AWT), .A_WIDTH(AW), .D_WIDTH(DW), .D_LEVEL(1),
        .WBURST_LEN(BLEN), .RBURST_LEN(BLEN), .NUM_PASSES(PASSES), .LFSR_SEED(SEED)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rdata(rdata),
`ifdef AXI_TEST_ERR_CAPTURE_EN
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .first_err_valid(first_err_valid),
`endif
        .error(error), .error_cnt(error_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [AW-1:0] exp_aw[$], exp_ar[$], obs_aw[$], obs_ar[$];
    logic [DW:0]   exp_w[$],  obs_w[$];       // {wlast, wdata}

    // ---------------- memory model and fault knobs ----------------
    logic [DW-1:0] mem [32];
    logic [AW-1:0] wr_ptr, rd_ptr;
    int            r_left, rburst_idx, wburst_idx;
    int            aw_st, w_st, ar_st;
    logic          stall_en, corrupt_en, drop_en, rresp_en, bresp_en;
    logic          corrupt_used, drop_used, rresp_used, bresp_used;
    logic          r_bad;
    int            cyc = 0;
    int            exp_err_cyc, err_cycles, stab_viol = 0;
    logic          err_on_time;
    logic          aw_wait, w_wait, ar_wait;
    logic [AW-1:0] aw_hold, ar_hold;
    logic [DW:0]   w_hold;
    logic          fault_beat;

    assign awready = (aw_st == 0);
    assign wready  = (w_st == 0);
    assign arready = (ar_st == 0);

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_st <= 0; w_st <= 0; ar_st <= 0;
            wr_ptr <= '0; rd_ptr <= '0; r_left <= 0;
            rburst_idx <= 0; wburst_idx <= 0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rdata <= '0; rlast <= 1'b0; rresp <= 2'b00; r_bad <= 1'b0;
            corrupt_used <= 1'b0; drop_used <= 1'b0; rresp_used <= 1'b0; bresp_used <= 1'b0;
            exp_err_cyc <= -1; err_cycles <= 0; err_on_time <= 1'b0;
            aw_wait <= 1'b0; w_wait <= 1'b0; ar_wait <= 1'b0;
            obs_aw.delete(); obs_ar.delete(); obs_w.delete();
        end else begin
            // ready stalls: 5 low cycles at random when enabled
            if (aw_st > 0) aw_st <= aw_st - 1;
            else if (stall_en && $urandom_range(0, 3) == 0) aw_st <= 5;
            if (w_st > 0) w_st <= w_st - 1;
            else if (stall_en && $urandom_range(0, 3) == 0) w_st <= 5;
            if (ar_st > 0) ar_st <= ar_st - 1;
            else if (stall_en && $urandom_range(0, 3) == 0) ar_st <= 5;

            // stability while valid && !ready
            if (aw_wait && !(awvalid && awaddr == aw_hold)) stab_viol <= stab_viol + 1;
            if (w_wait && !(wvalid && {wlast, wdata} == w_hold)) stab_viol <= stab_viol + 1;
            if (ar_wait && !(arvalid && araddr == ar_hold)) stab_viol <= stab_viol + 1;
            aw_wait <= awvalid && !awready; aw_hold <= awaddr;
            w_wait  <= wvalid && !wready;   w_hold  <= {wlast, wdata};
            ar_wait <= arvalid && !arready; ar_hold <= araddr;

            // a new run rearms the one-shot faults and the error monitors
            if (start) begin
                corrupt_used <= 1'b0; drop_used <= 1'b0; rresp_used <= 1'b0; bresp_used <= 1'b0;
                rburst_idx <= 0; wburst_idx <= 0;
                exp_err_cyc <= -1; err_cycles <= 0; err_on_time <= 1'b0;
            end

            if (rvalid && r_bad) exp_err_cyc <= cyc + 1;
            if (cyc == exp_err_cyc) err_on_time <= error;
            if (error) err_cycles <= err_cycles + 1;

            // write side
            if (bvalid && bready) bvalid <= 1'b0;
            if (awvalid && awready) begin
                obs_aw.push_back(awaddr);
                wr_ptr <= awaddr;
            end
            if (wvalid && wready) begin
                obs_w.push_back({wlast, wdata});
                mem[wr_ptr[5:1]] <= wdata;
                wr_ptr <= wr_ptr + 2;
                if (wlast) begin
                    bvalid <= 1'b1;
                    if (bresp_en && !bresp_used && wburst_idx == 1) begin
                        bresp <= 2'b10; bresp_used <= 1'b1;
                    end else begin
                        bresp <= 2'b00;
                    end
                    wburst_idx <= wburst_idx + 1;
                end
            end

            // read side
            if (r_left > 0) begin
                fault_beat = corrupt_en && !corrupt_used && rd_ptr == AW'(8'h12);
                rvalid <= 1'b1;
                rdata  <= mem[rd_ptr[5:1]] ^ (fault_beat ? 16'h0100 : 16'h0000);
                r_bad  <= fault_beat;
                if (fault_beat) corrupt_used <= 1'b1;
                if (r_left == 1 && drop_en && !drop_used && rburst_idx == 2) begin
                    rlast <= 1'b0; drop_used <= 1'b1;
                end else begin
                    rlast <= (r_left == 1);
                end
                if (rresp_en && !rresp_used && rd_ptr == AW'(8'h2A)) begin
                    rresp <= 2'b10; rresp_used <= 1'b1;
                end else begin
                    rresp <= 2'b00;
                end
                rd_ptr <= rd_ptr + 2;
                r_left <= r_left - 1;
                if (r_left == 1) rburst_idx <= rburst_idx + 1;
            end else begin
                rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; r_bad <= 1'b0;
            end
            if (arvalid && arready) begin
                obs_ar.push_back(araddr);
                rd_ptr <= araddr;
                r_left <= int'(arlen) + 1;
            end
        end
    end

    // ---------------- reference pattern model ----------------
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    task automatic push_expected(input logic [1:0] m);
        logic [31:0]   l;
        logic [DW-1:0] d;
        int            a;
        for (int p = 0; p < PASSES; p++) begin
            l = SEED;
            for (int b = 0; b < BURSTS; b++) begin
                exp_aw.push_back(AW'(b * 8));
                exp_ar.push_back(AW'(b * 8));
                for (int k = 0; k < 4; k++) begin
                    a = b * 8 + k * 2;
                    case (m)
                        2'd1:    d = ~DW'(a);
                        2'd2:    d = l[DW-1:0];
                        default: d = DW'(a);
                    endcase
                    l = lfsr_next(l);
                    exp_w.push_back({k == 3, d});
                end
            end
        end
    endtask

    task automatic drain();
        while (obs_aw.size() > 0) begin
            if (exp_aw.size() == 0) check("aw_unexpected", obs_aw.pop_front(), '1);
            else check("awaddr", obs_aw.pop_front(), exp_aw.pop_front());
        end
        while (obs_w.size() > 0) begin
            if (exp_w.size() == 0) check("w_unexpected", obs_w.pop_front(), '1);
            else check("wlast_wdata", obs_w.pop_front(), exp_w.pop_front());
        end
        while (obs_ar.size() > 0) begin
            if (exp_ar.size() == 0) check("ar_unexpected", obs_ar.pop_front(), '1);
            else check("araddr", obs_ar.pop_front(), exp_ar.pop_front());
        end
    endtask

    // Mode is changed right after the start pulse to prove it was latched.
    task automatic start_run(input logic [1:0] m);
        push_expected(m);
        mode  = m;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        mode  = m ^ 2'd1;
        check("busy_after_start", busy, 1'b1);
        check("done_cleared", done, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 8000) begin
            @(negedge aclk);
            drain();
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_pass_cnt"}, pass_cnt, 8'(PASSES));
        check({tag, "_w_left"}, exp_w.size(), 0);
        check({tag, "_aw_left"}, exp_aw.size(), 0);
        check({tag, "_ar_left"}, exp_ar.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; mode = 2'd0;
        stall_en = 1'b0; corrupt_en = 1'b0; drop_en = 1'b0; rresp_en = 1'b0; bresp_en = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);

        // reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_pass_cnt", pass_cnt, 8'd0);
        check("rst_error_cnt", error_cnt, 16'd0);
        check("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("rst_awaddr", awaddr, '0);
        check("rst_araddr", araddr, '0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // mode 0 on an ideal memory; a start while busy must be ignored
        start_run(2'd0);
        repeat (20) begin @(negedge aclk); drain(); end
        mode = 2'd1; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_done("mode0");
        check("mode0_error_cnt", error_cnt, 16'd0);
        check("mode0_err_pulses", err_cycles, 0);

        // inverted increment (first beat 16'hFFFF), then LFSR on the same memory
        start_run(2'd1);
        wait_done("mode1");
        check("mode1_error_cnt", error_cnt, 16'd0);
        start_run(2'd2);
        wait_done("mode2");
        check("mode2_error_cnt", error_cnt, 16'd0);

        // injected faults: corrupt rdata @0x12, dropped rlast on 3rd read
        // burst, rresp=2'b10 @0x2A, bresp=2'b10 on 2nd write burst
        corrupt_en = 1'b1; drop_en = 1'b1; rresp_en = 1'b1; bresp_en = 1'b1;
        start_run(2'd0);
        wait_done("fault");
        check("fault_error_cnt", error_cnt, 16'd4);
        check("fault_err_pulses", err_cycles, 4);
        check("fault_err_1cyc_later", err_on_time, 1'b1);
`ifdef AXI_TEST_ERR_CAPTURE_EN
        check("first_err_valid", first_err_valid, 1'b1);
        check("first_err_addr", first_err_addr, AW'(8'h12));
        check("first_err_data", first_err_data, 16'h0112);
`endif
        corrupt_en = 1'b0; drop_en = 1'b0; rresp_en = 1'b0; bresp_en = 1'b0;

        // random 5-cycle ready stalls: same result, no movement while stalled
        stall_en = 1'b1;
        start_run(2'd0);
        wait_done("stall");
        check("stall_error_cnt", error_cnt, 16'd0);
        check("stall_stability", stab_viol, 0);
        stall_en = 1'b0;
`ifdef AXI_TEST_ERR_CAPTURE_EN
        check("stall_first_err_clear", first_err_valid, 1'b0);
`endif

        // reset in the middle of the write phase, then a clean restart
        start_run(2'd0);
        for (int n = 0; n < 400 && exp_w.size() > BEATS * PASSES - 6; n++) begin
            @(negedge aclk);
            drain();
        end
        check("midw_reached", (exp_w.size() <= BEATS * PASSES - 6), 1'b1);
        aresetn = 1'b0;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        repeat (2) @(negedge aclk);
        check("midw_rst_busy", busy, 1'b0);
        check("midw_rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("midw_rst_error_cnt", error_cnt, 16'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        start_run(2'd0);
        wait_done("restart");
        check("restart_error_cnt", error_cnt, 16'd0);
        check("final_stability", stab_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
